// File: rtl/risa_pkg.sv
// Shared definitions for the kernel command scheduler: bus width, opcodes,
// FSM states and the bit layout of the status word.
package risa_pkg;

    localparam int unsigned AXI_LITE_WORD_WIDTH = 32;

    // Command opcodes written by the register block
    localparam logic [7:0] OpNop       = 8'h00;
    localparam logic [7:0] OpRun       = 8'h01;
    localparam logic [7:0] OpAbort     = 8'h02;
    localparam logic [7:0] OpClrStatus = 8'h03;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitDone
    } sched_state_e;

    // sched_status bit positions
    localparam int unsigned StatBusy        = 0;
    localparam int unsigned StatFifoFull    = 1;
    localparam int unsigned StatFifoEmpty   = 2;
    localparam int unsigned StatOverflow    = 3;
    localparam int unsigned StatIllegal     = 4;
    localparam int unsigned StatTimeout     = 5;
    localparam int unsigned StatEngineError = 6;
    localparam int unsigned StatLastOpLsb   = 8;
    localparam int unsigned StatCountLsb    = 16;

    // One queued command as stored in the FIFO
    typedef struct packed {
        logic [7:0]                     opcode;
        logic [AXI_LITE_WORD_WIDTH-1:0] arg;
    } sched_cmd_t;

endpackage

// File: rtl/sched_cmd_fifo.sv
// Synchronous command FIFO with registered full/empty and a one-cycle flush.
// A push is accepted while full if a pop happens in the same cycle.
// Depth must be a power of two and at least 2.
module sched_cmd_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(Depth);
    localparam int unsigned CntW  = AddrW + 1;

    logic [Width-1:0] mem_q [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_eff;
    logic             pop_eff;

    assign pop_eff  = pop && !empty_q;
    assign push_eff = push && (!full_q || pop_eff);
    assign rdata    = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;

    // Next-state for pointers, occupancy and the registered flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_eff) begin
                wr_ptr_d = wr_ptr_q + AddrW'(1);
            end
            if (pop_eff) begin
                rd_ptr_d = rd_ptr_q + AddrW'(1);
            end
            unique case ({push_eff, pop_eff})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
        full_d  = (count_d == CntW'(Depth));
        empty_d = (count_d == '0);
    end

    // Pointer and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage; contents are don't-care until written so no reset is needed
    always_ff @(posedge clk) begin
        if (push_eff && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/kernel_cmd_sched.sv
// Kernel command scheduler: queues RUN commands from the register block,
// dispatches them one at a time to the engine, supervises completion with a
// timeout and reports sticky status.
module kernel_cmd_sched
    import risa_pkg::*;
#(
    parameter int unsigned CMD_FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     kernel_command,
    input  logic                           kernel_command_new,
    input  logic [AXI_LITE_WORD_WIDTH-1:0] kernel_arg,
    input  logic                           state_lock,
    output logic                           engine_start,
    output logic [7:0]                     engine_opcode,
    output logic [AXI_LITE_WORD_WIDTH-1:0] engine_arg,
    input  logic                           engine_done,
    input  logic                           engine_err,
    output logic                           engine_abort,
    output logic [AXI_LITE_WORD_WIDTH-1:0] sched_status
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

    sched_state_e state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              abort_q, abort_d;
    logic [7:0]        eng_op_q;
    logic [AXI_LITE_WORD_WIDTH-1:0] eng_arg_q;
    logic [7:0]        last_op_q, last_op_d;
    logic [15:0]       count_q, count_d;
    logic              overflow_q, illegal_q, timeout_q, eng_err_q;

    logic       is_run, is_abort, is_clr, is_illegal;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    sched_cmd_t fifo_wdata, fifo_rdata;
    logic       done_inc, timeout_set, err_set, overflow_set;

    // Decode the strobed command
    always_comb begin
        is_run     = 1'b0;
        is_abort   = 1'b0;
        is_clr     = 1'b0;
        is_illegal = 1'b0;
        if (kernel_command_new) begin
            case (kernel_command)
                OpNop:       ;
                OpRun:       is_run = 1'b1;
                OpAbort:     is_abort = 1'b1;
                OpClrStatus: is_clr = 1'b1;
                default:     is_illegal = 1'b1;
            endcase
        end
    end

    assign fifo_wdata   = '{opcode: kernel_command, arg: kernel_arg};
    assign fifo_push    = is_run && (!fifo_full || fifo_pop);
    assign overflow_set = is_run && fifo_full && !fifo_pop;

    sched_cmd_fifo #(
        .Depth (CMD_FIFO_DEPTH),
        .Width ($bits(sched_cmd_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .flush (is_abort),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Dispatch FSM: next state, pop, abort pulse and completion events
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        abort_d     = 1'b0;
        fifo_pop    = 1'b0;
        done_inc    = 1'b0;
        timeout_set = 1'b0;
        err_set     = 1'b0;
        case (state_q)
            StIdle: begin
                // An ABORT in this cycle flushes, so nothing may be popped
                if (!is_abort && !fifo_empty && !state_lock) begin
                    state_d  = StIssue;
                    fifo_pop = 1'b1;
                end
            end
            StIssue: begin
                timer_d = '0;
                if (is_abort) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (is_abort) begin
                    state_d = StIdle;
                    abort_d = 1'b1;
                end else if (engine_done) begin
                    // Completion beats a coincident timeout
                    state_d  = StIdle;
                    done_inc = 1'b1;
                    err_set  = engine_err;
                end else if (timer_q == TimerLast) begin
                    state_d     = StIdle;
                    abort_d     = 1'b1;
                    timeout_set = 1'b1;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Completed count and last-opcode next state; a same-cycle event survives a clear
    always_comb begin
        count_d = (is_clr ? 16'd0 : count_q) + {15'd0, done_inc};
        if (fifo_pop) begin
            last_op_d = fifo_rdata.opcode;
        end else if (is_clr) begin
            last_op_d = 8'h00;
        end else begin
            last_op_d = last_op_q;
        end
    end

    // State, dispatch registers and sticky status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            abort_q    <= 1'b0;
            eng_op_q   <= '0;
            eng_arg_q  <= '0;
            last_op_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            eng_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            abort_q    <= abort_d;
            last_op_q  <= last_op_d;
            count_q    <= count_d;
            if (fifo_pop) begin
                eng_op_q  <= fifo_rdata.opcode;
                eng_arg_q <= fifo_rdata.arg;
            end
            overflow_q <= (overflow_q && !is_clr) || overflow_set;
            illegal_q  <= (illegal_q && !is_clr) || is_illegal;
            timeout_q  <= (timeout_q && !is_clr) || timeout_set;
            eng_err_q  <= (eng_err_q && !is_clr) || err_set;
        end
    end

    assign engine_start  = (state_q == StIssue);
    assign engine_abort  = abort_q;
    assign engine_opcode = eng_op_q;
    assign engine_arg    = eng_arg_q;

    // Status word for the register block read path
    always_comb begin
        sched_status = '0;
        sched_status[StatBusy]        = (state_q != StIdle);
        sched_status[StatFifoFull]    = fifo_full;
        sched_status[StatFifoEmpty]   = fifo_empty;
        sched_status[StatOverflow]    = overflow_q;
        sched_status[StatIllegal]     = illegal_q;
        sched_status[StatTimeout]     = timeout_q;
        sched_status[StatEngineError] = eng_err_q;
        sched_status[StatLastOpLsb +: 8] = last_op_q;
        sched_status[StatCountLsb +: 16] = count_q;
    end

endmodule

// File: tb/tb_kernel_cmd_sched.sv
// Scoreboard bench for kernel_cmd_sched: stimulus pushes expected dispatches
// and abort pulses into queues, a negedge monitor pops and compares them.
module tb_kernel_cmd_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  kernel_command = 8'h00;
    logic        kernel_command_new = 1'b0;
    logic [31:0] kernel_arg = 32'h0;
    logic        state_lock = 1'b0;
    logic        engine_start;
    logic [7:0]  engine_opcode;
    logic [31:0] engine_arg;
    logic        engine_done = 1'b0;
    logic        engine_err = 1'b0;
    logic        engine_abort;
    logic [31:0] sched_status;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [31:0] arg;
        int          due;
    } start_exp_t;

    start_exp_t start_q[$];
    int         abort_q[$];

    kernel_cmd_sched #(
        .CMD_FIFO_DEPTH (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .kernel_command     (kernel_command),
        .kernel_command_new (kernel_command_new),
        .kernel_arg         (kernel_arg),
        .state_lock         (state_lock),
        .engine_start       (engine_start),
        .engine_opcode      (engine_opcode),
        .engine_arg         (engine_arg),
        .engine_done        (engine_done),
        .engine_err         (engine_err),
        .engine_abort       (engine_abort),
        .sched_status       (sched_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every start/abort the DUT presents must match the head of its queue
    always @(negedge clk) begin
        if (!rst) begin
            if (engine_start) begin
                if (start_q.size() == 0) begin
                    check_eq("start_unexpected", 32'(engine_start), 32'h0);
                end else begin
                    start_exp_t e;
                    e = start_q.pop_front();
                    check_eq("start_arg", engine_arg, e.arg);
                    check_eq("start_opcode", 32'(engine_opcode), 32'h01);
                    if (e.due >= 0) check_eq("start_cycle", 32'(cyc), 32'(e.due));
                end
            end
            if (engine_abort) begin
                if (abort_q.size() == 0) begin
                    check_eq("abort_unexpected", 32'(engine_abort), 32'h0);
                end else begin
                    int due;
                    due = abort_q.pop_front();
                    check_eq("abort_cycle", 32'(cyc), 32'(due));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [31:0] arg);
        kernel_command     = op;
        kernel_arg         = arg;
        kernel_command_new = 1'b1;
        step(1);
        kernel_command_new = 1'b0;
        kernel_command     = 8'h00;
        kernel_arg         = 32'h0;
    endtask

    task automatic expect_start(input logic [31:0] arg, input int due);
        start_exp_t e;
        e.arg = arg;
        e.due = due;
        start_q.push_back(e);
    endtask

    // Wait (bounded) for the next dispatch, then complete it one cycle later
    task automatic complete_next();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (engine_start) seen = 1'b1;
            else step(1);
        end
        check_eq("dispatch_wait", 32'(seen), 32'h1);
        step(1);
        engine_done = 1'b1;
        step(1);
        engine_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c;
        // Reset values
        step(2);
        check_eq("rst_status", sched_status, 32'h0000_0004);
        check_eq("rst_start", 32'(engine_start), 32'h0);
        check_eq("rst_abort", 32'(engine_abort), 32'h0);
        check_eq("rst_opcode", 32'(engine_opcode), 32'h0);
        check_eq("rst_arg", engine_arg, 32'h0);
        rst = 1'b0;
        step(2);

        // Single RUN into an idle block: start two cycles after the strobe
        c = cyc;
        expect_start(32'h0000_1234, c + 2);
        send(8'h01, 32'h0000_1234);
        step(2);
        engine_done = 1'b1;
        step(1);
        engine_done = 1'b0;
        check_eq("single_run_status", sched_status, 32'h0001_0104);

        // Five RUNs with the engine stalled fill the depth-4 FIFO; the sixth overflows
        c = cyc;
        expect_start(32'hA000_0000, c + 2);
        for (int i = 1; i < 5; i++) expect_start(32'hA000_0000 + 32'(i), -1);
        for (int i = 0; i < 5; i++) send(8'h01, 32'hA000_0000 + 32'(i));
        check_eq("fill_status", sched_status, 32'h0001_0103);
        send(8'h01, 32'hA000_0005);
        check_eq("overflow_status", sched_status, 32'h0001_010B);
        engine_done = 1'b1;
        step(1);
        engine_done = 1'b0;
        for (int i = 0; i < 4; i++) complete_next();
        check_eq("drain_status", sched_status, 32'h0006_010C);

        // Timeout: abort 16 cycles after WAIT_DONE entry, then the queued command goes
        c = cyc;
        expect_start(32'hB000_0000, c + 2);
        abort_q.push_back(c + 19);
        expect_start(32'hB000_0001, c + 20);
        send(8'h01, 32'hB000_0000);
        send(8'h01, 32'hB000_0001);
        step(19);
        engine_done = 1'b1;
        step(1);
        engine_done = 1'b0;
        check_eq("timeout_status", sched_status, 32'h0007_012C);

        // ABORT during WAIT_DONE with three queued: pulse, flush, count unchanged
        c = cyc;
        expect_start(32'hD000_0000, c + 2);
        for (int i = 0; i < 4; i++) send(8'h01, 32'hD000_0000 + 32'(i));
        abort_q.push_back(c + 5);
        send(8'h02, 32'h0);
        step(1);
        check_eq("abort_status", sched_status, 32'h0007_012C);
        step(4);

        // Illegal opcode, then CLR_STATUS
        send(8'h7F, 32'h0);
        check_eq("illegal_status", sched_status, 32'h0007_013C);
        send(8'h03, 32'h0);
        check_eq("clr_status", sched_status, 32'h0000_0004);

        // state_lock holds a queued RUN until released; completion with engine_err
        state_lock = 1'b1;
        send(8'h01, 32'hE000_0000);
        step(5);
        check_eq("locked_status", sched_status, 32'h0000_0000);
        c = cyc;
        expect_start(32'hE000_0000, c + 1);
        state_lock = 1'b0;
        step(2);
        engine_done = 1'b1;
        engine_err  = 1'b1;
        step(1);
        engine_done = 1'b0;
        engine_err  = 1'b0;
        check_eq("err_status", sched_status, 32'h0001_0144);

        // CLR_STATUS coincident with an engine error: the error bit stays set
        c = cyc;
        expect_start(32'hF000_0000, c + 2);
        send(8'h01, 32'hF000_0000);
        step(2);
        engine_done        = 1'b1;
        engine_err         = 1'b1;
        kernel_command     = 8'h03;
        kernel_command_new = 1'b1;
        step(1);
        engine_done        = 1'b0;
        engine_err         = 1'b0;
        kernel_command_new = 1'b0;
        kernel_command     = 8'h00;
        check_eq("clr_vs_err_bit", 32'(sched_status[6]), 32'h1);
        check_eq("clr_vs_illegal_bit", 32'(sched_status[4]), 32'h0);

        // Reset mid-WAIT_DONE drops everything without an abort pulse
        c = cyc;
        expect_start(32'h6000_0000, c + 2);
        send(8'h01, 32'h6000_0000);
        send(8'h01, 32'h6000_0001);
        step(1);
        rst = 1'b1;
        step(2);
        check_eq("midrst_status", sched_status, 32'h0000_0004);
        check_eq("midrst_abort", 32'(engine_abort), 32'h0);
        rst = 1'b0;
        step(6);
        check_eq("postrst_status", sched_status, 32'h0000_0004);

        check_eq("start_queue_left", 32'(start_q.size()), 32'h0);
        check_eq("abort_queue_left", 32'(abort_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
